// File: rtl/instr_decode.sv
// Decode stage: turns fetched opcode words into registered execute controls.
// Ports: clk, rst_n, opcode_in, zero_flag -> br, alu_op, rd/rs/rt, reg_we, imm, imm_valid, halt, illegal, instr_count.
module instr_decode #(
   parameter int COUNT_W = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [15:0]        opcode_in,
   input  logic               zero_flag,
   output logic               br,
   output logic [3:0]         alu_op,
   output logic [3:0]         rd,
   output logic [3:0]         rs,
   output logic [3:0]         rt,
   output logic               reg_we,
   output logic [15:0]        imm,
   output logic               imm_valid,
   output logic               halt,
   output logic               illegal,
   output logic [COUNT_W-1:0] instr_count
);

   typedef enum logic [1:0] {
      S_DECODE,
      S_OPERAND,
      S_SKIP,
      S_HALT
   } state_t;

   state_t state_q, state_d;

   // Set while the OPERAND word belongs to an LDI (otherwise a taken branch).
   logic pend_ldi_q, pend_ldi_d;

   logic               br_d, reg_we_d, imm_valid_d, illegal_d, halt_d;
   logic [3:0]         alu_op_d, rd_d, rs_d, rt_d;
   logic [15:0]        imm_d;
   logic [COUNT_W-1:0] cnt_d;
   logic [3:0]         op;

   assign op = opcode_in[15:12];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_DECODE;
         pend_ldi_q  <= 1'b0;
         br          <= 1'b0;
         alu_op      <= '0;
         rd          <= '0;
         rs          <= '0;
         rt          <= '0;
         reg_we      <= 1'b0;
         imm         <= '0;
         imm_valid   <= 1'b0;
         halt        <= 1'b0;
         illegal     <= 1'b0;
         instr_count <= '0;
      end else begin
         state_q     <= state_d;
         pend_ldi_q  <= pend_ldi_d;
         br          <= br_d;
         alu_op      <= alu_op_d;
         rd          <= rd_d;
         rs          <= rs_d;
         rt          <= rt_d;
         reg_we      <= reg_we_d;
         imm         <= imm_d;
         imm_valid   <= imm_valid_d;
         halt        <= halt_d;
         illegal     <= illegal_d;
         instr_count <= cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      pend_ldi_d  = pend_ldi_q;
      br_d        = 1'b0;
      reg_we_d    = 1'b0;
      imm_valid_d = 1'b0;
      illegal_d   = 1'b0;
      halt_d      = halt;
      alu_op_d    = alu_op;
      rd_d        = rd;
      rs_d        = rs;
      rt_d        = rt;
      imm_d       = imm;
      cnt_d       = instr_count;

      unique case (state_q)
         S_DECODE: begin
            if (op <= 4'h5 || op == 4'hF) begin
               alu_op_d = op;
               rd_d     = opcode_in[11:8];
               rs_d     = opcode_in[7:4];
               rt_d     = opcode_in[3:0];
            end
            unique case (op)
               4'h0: cnt_d = instr_count + COUNT_W'(1);
               4'h1, 4'h2: begin
                  reg_we_d = 1'b1;
                  cnt_d    = instr_count + COUNT_W'(1);
               end
               4'h3: begin
                  pend_ldi_d = 1'b1;
                  state_d    = S_OPERAND;
               end
               4'h4: begin
                  pend_ldi_d = 1'b0;
                  br_d       = 1'b1;
                  state_d    = S_OPERAND;
               end
               4'h5: begin
                  pend_ldi_d = 1'b0;
                  // Not-taken BZ still has to swallow its target word.
                  br_d       = zero_flag;
                  state_d    = zero_flag ? S_OPERAND : S_SKIP;
               end
               4'hF: begin
                  halt_d  = 1'b1;
                  cnt_d   = instr_count + COUNT_W'(1);
                  state_d = S_HALT;
               end
               default: begin
                  // Undefined opcode retires as a NOP with a flag pulse.
                  alu_op_d  = 4'h0;
                  illegal_d = 1'b1;
                  cnt_d     = instr_count + COUNT_W'(1);
               end
            endcase
         end
         S_OPERAND: begin
            if (pend_ldi_q) begin
               imm_d       = opcode_in;
               imm_valid_d = 1'b1;
               reg_we_d    = 1'b1;
            end
            pend_ldi_d = 1'b0;
            cnt_d      = instr_count + COUNT_W'(1);
            state_d    = S_DECODE;
         end
         S_SKIP: begin
            cnt_d   = instr_count + COUNT_W'(1);
            state_d = S_DECODE;
         end
         S_HALT: begin
            state_d = S_HALT;
         end
         default: state_d = S_DECODE;
      endcase
   end

endmodule

// File: tb/tb_instr_decode.sv
// Testbench for instr_decode: directed and random word streams vs. an instruction-level model.
// Drives opcode_in/zero_flag per cycle and compares every output one step after each edge.
module tb_instr_decode;

   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [15:0]   opcode_in;
   logic          zero_flag;
   logic          br, reg_we, imm_valid, halt, illegal;
   logic [3:0]    alu_op, rd, rs, rt;
   logic [15:0]   imm;
   logic [CW-1:0] instr_count;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: what the next word means and the expected outputs.
   // pend: 0 none, 1 LDI immediate, 2 taken-branch target, 3 skipped target.
   int          pend;
   bit          halted;
   logic        e_br, e_we, e_iv, e_ill, e_halt;
   logic [3:0]  e_alu, e_rd, e_rs, e_rt;
   logic [15:0] e_imm;
   int          e_cnt;

   instr_decode #(.COUNT_W(CW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .opcode_in   (opcode_in),
      .zero_flag   (zero_flag),
      .br          (br),
      .alu_op      (alu_op),
      .rd          (rd),
      .rs          (rs),
      .rt          (rt),
      .reg_we      (reg_we),
      .imm         (imm),
      .imm_valid   (imm_valid),
      .halt        (halt),
      .illegal     (illegal),
      .instr_count (instr_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      pend = 0; halted = 0;
      e_br = 0; e_we = 0; e_iv = 0; e_ill = 0; e_halt = 0;
      e_alu = 0; e_rd = 0; e_rs = 0; e_rt = 0; e_imm = 0; e_cnt = 0;
   endtask

   task automatic model_step(input logic [15:0] w, input logic z);
      int op;
      op = int'(w[15:12]);
      e_br = 0; e_we = 0; e_iv = 0; e_ill = 0;
      if (halted) return;
      if (pend != 0) begin
         if (pend == 1) begin
            e_imm = w; e_iv = 1; e_we = 1;
         end
         e_cnt = (e_cnt + 1) % (1 << CW);
         pend = 0;
         return;
      end
      if (op >= 6 && op <= 14) begin
         e_alu = 0; e_ill = 1;
         e_cnt = (e_cnt + 1) % (1 << CW);
         return;
      end
      e_alu = w[15:12]; e_rd = w[11:8]; e_rs = w[7:4]; e_rt = w[3:0];
      if (op == 3) pend = 1;
      else if (op == 4) begin pend = 2; e_br = 1; end
      else if (op == 5) begin pend = z ? 2 : 3; e_br = z; end
      else begin
         if (op == 1 || op == 2) e_we = 1;
         if (op == 15) begin halted = 1; e_halt = 1; end
         e_cnt = (e_cnt + 1) % (1 << CW);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".br"}, 32'(br), 32'(e_br));
      check({tag, ".reg_we"}, 32'(reg_we), 32'(e_we));
      check({tag, ".imm_valid"}, 32'(imm_valid), 32'(e_iv));
      check({tag, ".illegal"}, 32'(illegal), 32'(e_ill));
      check({tag, ".halt"}, 32'(halt), 32'(e_halt));
      check({tag, ".alu_op"}, 32'(alu_op), 32'(e_alu));
      check({tag, ".rd"}, 32'(rd), 32'(e_rd));
      check({tag, ".rs"}, 32'(rs), 32'(e_rs));
      check({tag, ".rt"}, 32'(rt), 32'(e_rt));
      check({tag, ".imm"}, 32'(imm), 32'(e_imm));
      check({tag, ".count"}, 32'(instr_count), 32'(e_cnt));
   endtask

   task automatic step(input string tag, input logic [15:0] w, input logic z);
      opcode_in = w;
      zero_flag = z;
      @(posedge clk);
      #1;
      model_step(w, z);
      check_all(tag);
   endtask

   task automatic do_reset();
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all("reset");
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      logic [15:0] w;
      logic [3:0]  op;
      rst_n     = 1'b1;
      opcode_in = 16'h0000;
      zero_flag = 1'b0;
      model_reset();
      do_reset();

      // LDI with immediate that looks like an opcode
      step("ldi_op", 16'h3500, 1'b0);
      step("ldi_imm", 16'hBEEF, 1'b0);
      check("ldi_rd5", 32'(rd), 32'h5);
      step("after_ldi", 16'h0000, 1'b0);

      // BR then target; the word after is a normal decode
      step("br_op", 16'h4000, 1'b0);
      check("br_high_on_target", 32'(br), 32'h1);
      step("br_tgt", 16'h0020, 1'b0);
      step("br_next", 16'h2456, 1'b0);

      // BZ not taken and taken
      step("bz_nt", 16'h5000, 1'b0);
      step("bz_nt_tgt", 16'h0010, 1'b1);
      step("bz_t", 16'h5000, 1'b1);
      step("bz_t_tgt", 16'h0010, 1'b0);

      // Illegal opcode
      step("ill", 16'h7123, 1'b0);
      step("ill_next", 16'h0000, 1'b0);

      // Reset in the middle of an LDI, then ADD
      step("ldi_rst", 16'h3900, 1'b0);
      do_reset();
      step("add_after_rst", 16'h1123, 1'b0);

      // Random stream, no HALT decodes (operand words fully random)
      for (int i = 0; i < 300; i++) begin
         if (pend != 0) w = 16'($urandom);
         else begin
            op = 4'($urandom_range(0, 14));
            w  = {op, 12'($urandom)};
         end
         step("rand", w, 1'($urandom));
      end

      // HALT is sticky; later ADDs ignored
      step("halt", 16'hF000, 1'b0);
      for (int i = 0; i < 4; i++) step("halted_add", 16'h1321, 1'b1);

      // Counter wrap with 17 NOPs
      do_reset();
      for (int i = 0; i < 17; i++) step("wrap_nop", 16'h0000, 1'b0);
      check("wrap_final", 32'(instr_count), 32'h1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
